// File: rtl/vmem_integrator.sv
// Membrane-potential integrator: accumulates IPSC beats into Vmem, then per timestep applies
// leak toward Vrest (exact restoring divide by Taumem), thresholds, fires and holds refractory.
module vmem_integrator #(
  parameter int INTEGER_WIDTH   = 32,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int DELTAT_WIDTH    = 4,
  parameter int REFRAC_WIDTH    = 8
) (
  input  logic                     Clock_i,
  input  logic                     Reset_i,
  input  logic [DATA_WIDTH-1:0]    IPSCIn_i,
  input  logic                     IPSCValid_i,
  output logic                     IPSCReady_o,
  input  logic                     StepStart_i,
  input  logic [INTEGER_WIDTH-1:0] Vrest_i,
  input  logic [INTEGER_WIDTH-1:0] Vthresh_i,
  input  logic [INTEGER_WIDTH-1:0] Vreset_i,
  input  logic [DELTAT_WIDTH-1:0]  DeltaT_i,
  input  logic [INTEGER_WIDTH-1:0] Taumem_i,
  input  logic [REFRAC_WIDTH-1:0]  RefracPeriod_i,
  output logic [DATA_WIDTH-1:0]    VmemOut_o,
  output logic                     SpikeOut_o,
  output logic                     StepDone_o
);
  localparam int DW  = DATA_WIDTH;
  localparam int IW  = INTEGER_WIDTH;
  localparam int FW  = DATA_WIDTH_FRAC;
  localparam int DTW = DELTAT_WIDTH;
  localparam int CW  = $clog2(DW);
  localparam logic [DW-1:0] VMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] VMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_UPDATE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       vmem_q, vmem_d;
  logic [REFRAC_WIDTH-1:0] refrac_q, refrac_d, rperiod_q, rperiod_d;
  logic [IW-1:0]       vrest_q, vrest_d, vthresh_q, vthresh_d, vreset_q, vreset_d, tau_q, tau_d;
  logic [DTW-1:0]      dt_q, dt_d;
  logic                neg_q, neg_d, fired_q, fired_d;
  logic [DW-1:0]       dq_q, dq_d;      // dividend shifts out the top, quotient in at the bottom
  logic [IW-1:0]       rem_q, rem_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  function automatic logic [DW-1:0] sat(input logic [DW:0] s);
    if (s[DW] != s[DW-1]) return s[DW] ? VMIN : VMAX;
    return s[DW-1:0];
  endfunction

  logic signed [DW:0]      diff;
  logic [DW+DTW+1:0]       prod_full;
  logic [DW-1:0]           prod, leak, vnew, thr;
  logic [IW:0]             rem_sh, rem_sub;
  logic                    qbit;

  assign diff      = $signed({vrest_q[IW-1], vrest_q, {FW{1'b0}}}) - $signed({vmem_q[DW-1], vmem_q});
  assign prod_full = {{(DTW+1){diff[DW]}}, diff} * {{(DW+2){1'b0}}, dt_q};
  // DeltaT sits in the top fraction bits, so the Q slice is the product shifted right by DTW
  assign prod      = DW'(prod_full >> DTW);
  assign rem_sh    = {rem_q, dq_q[DW-1]};
  assign qbit      = rem_sh >= {1'b0, tau_q};
  assign rem_sub   = rem_sh - {1'b0, tau_q};
  assign leak      = (tau_q == '0) ? '0 : (neg_q ? -dq_q : dq_q);
  assign vnew      = sat({vmem_q[DW-1], vmem_q} + {leak[DW-1], leak});
  assign thr       = {vthresh_q, {FW{1'b0}}};

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q   <= S_IDLE;
      vmem_q    <= '0;
      refrac_q  <= '0;
      rperiod_q <= '0;
      vrest_q   <= '0;
      vthresh_q <= '0;
      vreset_q  <= '0;
      tau_q     <= '0;
      dt_q      <= '0;
      neg_q     <= 1'b0;
      fired_q   <= 1'b0;
      dq_q      <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      vmem_q    <= vmem_d;
      refrac_q  <= refrac_d;
      rperiod_q <= rperiod_d;
      vrest_q   <= vrest_d;
      vthresh_q <= vthresh_d;
      vreset_q  <= vreset_d;
      tau_q     <= tau_d;
      dt_q      <= dt_d;
      neg_q     <= neg_d;
      fired_q   <= fired_d;
      dq_q      <= dq_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vmem_d    = vmem_q;
    refrac_d  = refrac_q;
    rperiod_d = rperiod_q;
    vrest_d   = vrest_q;
    vthresh_d = vthresh_q;
    vreset_d  = vreset_q;
    tau_d     = tau_q;
    dt_d      = dt_q;
    neg_d     = neg_q;
    fired_d   = fired_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (IPSCValid_i && refrac_q == '0)
          vmem_d = sat({vmem_q[DW-1], vmem_q} + {IPSCIn_i[DW-1], IPSCIn_i});
        if (StepStart_i) begin
          vrest_d   = Vrest_i;
          vthresh_d = Vthresh_i;
          vreset_d  = Vreset_i;
          dt_d      = DeltaT_i;
          tau_d     = Taumem_i;
          rperiod_d = RefracPeriod_i;
          fired_d   = 1'b0;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        neg_d   = prod[DW-1];
        dq_d    = prod[DW-1] ? -prod : prod;
        rem_d   = '0;
        cnt_d   = CW'(DW-1);
        state_d = S_DIV;
      end
      S_DIV: begin
        dq_d  = {dq_q[DW-2:0], qbit};
        rem_d = qbit ? IW'(rem_sub) : IW'(rem_sh);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (refrac_q != '0) begin
          vmem_d   = {vreset_q, {FW{1'b0}}};
          refrac_d = refrac_q - 1'b1;
        end else if ($signed(vnew) >= $signed(thr)) begin
          vmem_d   = {vreset_q, {FW{1'b0}}};
          refrac_d = rperiod_q;
          fired_d  = 1'b1;
        end else begin
          vmem_d   = vnew;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign IPSCReady_o = (state_q == S_IDLE);
  assign StepDone_o  = (state_q == S_DONE);
  assign SpikeOut_o  = (state_q == S_DONE) && fired_q;
  assign VmemOut_o   = vmem_q;
endmodule

// File: tb/tb_vmem_integrator.sv
// Bench for vmem_integrator: event-level reference model of the neuron checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vmem_integrator;
  logic        Clock_i = 1'b0;
  logic        Reset_i = 1'b1;
  logic [63:0] IPSCIn_i = '0;
  logic        IPSCValid_i = 1'b0;
  logic        IPSCReady_o;
  logic        StepStart_i = 1'b0;
  logic [31:0] Vrest_i = '0, Vthresh_i = '0, Vreset_i = '0, Taumem_i = '0;
  logic [3:0]  DeltaT_i = '0;
  logic [7:0]  RefracPeriod_i = '0;
  logic [63:0] VmemOut_o;
  logic        SpikeOut_o, StepDone_o;

  vmem_integrator dut (
    .Clock_i(Clock_i), .Reset_i(Reset_i), .IPSCIn_i(IPSCIn_i), .IPSCValid_i(IPSCValid_i),
    .IPSCReady_o(IPSCReady_o), .StepStart_i(StepStart_i), .Vrest_i(Vrest_i),
    .Vthresh_i(Vthresh_i), .Vreset_i(Vreset_i), .DeltaT_i(DeltaT_i), .Taumem_i(Taumem_i),
    .RefracPeriod_i(RefracPeriod_i), .VmemOut_o(VmemOut_o), .SpikeOut_o(SpikeOut_o),
    .StepDone_o(StepDone_o)
  );

  always #5 Clock_i = ~Clock_i;

  int n_chk = 0, n_pass = 0;

  // Reference model: step result computed at acceptance, published 66 edges later.
  logic signed [63:0] m_vmem = '0, m_res = '0;
  int                 m_refrac = 0, m_res_refrac = 0, m_age = 67;
  bit                 m_done = 0, m_fire = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic signed [63:0] msat(input logic signed [127:0] v);
    logic signed [127:0] mx, mn;
    mx = 64'sh7FFF_FFFF_FFFF_FFFF;
    mn = -mx - 1;
    if (v > mx) return mx[63:0];
    if (v < mn) return mn[63:0];
    return v[63:0];
  endfunction

  task automatic model_reset();
    m_vmem = '0; m_refrac = 0; m_age = 67; m_done = 0; m_fire = 0;
  endtask

  task automatic model_step();
    logic signed [63:0]  vr64, vth64, pr64, vn;
    logic signed [127:0] d, p, lk, t;
    vr64  = {Vrest_i, 32'h0};
    vth64 = {Vthresh_i, 32'h0};
    if (m_refrac != 0) begin
      m_res = {Vreset_i, 32'h0}; m_res_refrac = m_refrac - 1; m_fire = 0;
    end else begin
      d = vr64;
      d = d - m_vmem;
      p = d * $signed({1'b0, DeltaT_i});
      p = p >>> 4;
      pr64 = p[63:0];
      lk = 0;
      if (Taumem_i != 0) lk = pr64 / $signed({1'b0, Taumem_i});
      t = m_vmem;
      t = t + lk;
      vn = msat(t);
      if (vn >= vth64) begin
        m_res = {Vreset_i, 32'h0}; m_res_refrac = RefracPeriod_i; m_fire = 1;
      end else begin
        m_res = vn; m_res_refrac = 0; m_fire = 0;
      end
    end
  endtask

  task automatic model_edge();
    logic signed [63:0]  ip;
    logic signed [127:0] t;
    m_done = 0;
    if (m_age >= 67) begin
      if (IPSCValid_i && m_refrac == 0) begin
        ip = IPSCIn_i;
        t = m_vmem;
        t = t + ip;
        m_vmem = msat(t);
      end
      if (StepStart_i) begin
        model_step();
        m_age = 0;
      end
    end else begin
      m_age++;
      if (m_age == 66) begin
        m_vmem = m_res; m_refrac = m_res_refrac; m_done = 1;
      end
    end
  endtask

  // Single compare point: every cycle, #1 after the rising edge.
  task automatic tick();
    @(posedge Clock_i);
    #1;
    if (!Reset_i) model_edge();
    else model_reset();
    chk("vmem",  VmemOut_o, m_vmem);
    chk("ready", 64'(IPSCReady_o), 64'(m_age >= 67));
    chk("done",  64'(StepDone_o), 64'(m_done));
    chk("spike", 64'(SpikeOut_o), 64'(m_done && m_fire));
    IPSCValid_i = 0;
    StepStart_i = 0;
  endtask

  task automatic do_reset();
    Reset_i = 1;
    #1;
    model_reset();
    chk("reset_vmem_async", VmemOut_o, 64'h0);
    repeat (3) tick();
    Reset_i = 0;
  endtask

  task automatic set_params(input int vr, input int vth, input int vrs, input int dt,
                            input int tau, input int rp);
    Vrest_i = vr; Vthresh_i = vth; Vreset_i = vrs;
    DeltaT_i = 4'(dt); Taumem_i = tau; RefracPeriod_i = 8'(rp);
  endtask

  task automatic beat(input logic [63:0] v);
    IPSCValid_i = 1; IPSCIn_i = v;
    tick();
  endtask

  // Starts a step (caller may pre-set an IPSC beat) and waits for StepDone, bounded.
  task automatic run_step(input logic [63:0] exp_vmem, input bit exp_spk);
    int cnt;
    StepStart_i = 1;
    tick();
    cnt = 0;
    while (!StepDone_o && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("latency", 64'(cnt), 64'd66);
    chk("step_vmem", VmemOut_o, exp_vmem);
    chk("step_spike", 64'(SpikeOut_o), 64'(exp_spk));
    tick();
  endtask

  initial begin
    logic [63:0] ip;
    longint      t;
    model_reset();
    repeat (2) @(posedge Clock_i);
    #1;
    do_reset();
    repeat (10) tick();
    chk("idle_vmem", VmemOut_o, 64'h0);
    chk("idle_ready", 64'(IPSCReady_o), 64'd1);

    // Pure leak from 0 toward -65
    set_params(-65, 10, -70, 8, 10, 0);
    run_step(64'hFFFF_FFFC_C000_0000, 0);

    // Three 5.0 beats, leak -4, spike to Vreset, refractory 2
    do_reset();
    set_params(-65, 10, -70, 8, 10, 2);
    repeat (3) beat(64'h0000_0005_0000_0000);
    chk("accum_15", VmemOut_o, 64'h0000_000F_0000_0000);
    run_step(64'hFFFF_FFBA_0000_0000, 1);
    repeat (2) begin
      beat(64'h0000_0064_0000_0000);
      chk("refrac_discard", VmemOut_o, 64'hFFFF_FFBA_0000_0000);
      run_step(64'hFFFF_FFBA_0000_0000, 0);
    end
    run_step(64'hFFFF_FFBA_4000_0000, 0);

    // Saturation, then a Taumem=0 step keeps constant latency
    do_reset();
    repeat (2) beat(64'h7FFF_FFFF_FFFF_FFFF);
    chk("sat_max", VmemOut_o, 64'h7FFF_FFFF_FFFF_FFFF);
    set_params(-65, 10, -70, 8, 0, 0);
    run_step(64'hFFFF_FFBA_0000_0000, 1);

    // Reset 20 cycles into DIV aborts the step
    set_params(-65, 10, -70, 8, 10, 0);
    StepStart_i = 1;
    tick();
    repeat (21) tick();
    do_reset();
    chk("abort_ready", 64'(IPSCReady_o), 64'd1);
    repeat (80) tick();

    // StepStart and IPSC in the same cycle: 20.0 accumulated, then leak -4.25
    set_params(-65, 100, -70, 8, 10, 0);
    IPSCValid_i = 1; IPSCIn_i = 64'h0000_0014_0000_0000;
    run_step(64'h0000_000F_C000_0000, 0);

    // Randomized traffic; params change every cycle so sampling at StepStart is exercised
    for (int i = 0; i < 3000; i++) begin
      Vrest_i   = 32'($urandom_range(30)) - 32'd80;
      Vthresh_i = 32'($urandom_range(80)) - 32'd60;
      Vreset_i  = 32'($urandom_range(20)) - 32'd80;
      DeltaT_i  = 4'($urandom);
      Taumem_i  = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(20));
      RefracPeriod_i = 8'($urandom_range(3));
      IPSCValid_i = ($urandom_range(9) < 6);
      if ($urandom_range(19) == 0) ip = {$urandom, $urandom};
      else begin
        t = longint'(int'($urandom));
        t = t <<< 4;
        ip = t;
      end
      IPSCIn_i = ip;
      StepStart_i = ($urandom_range(19) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
